// File: rtl/wb_dst_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_dst_tracker_pkg
// Description : Shared register-index constants and pipeline stage-entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_dst_tracker_pkg;

    localparam int c_REG_ADDR_W = 4;
    localparam int c_NUM_REGS   = 2 ** c_REG_ADDR_W;

    typedef struct packed {
        logic [c_REG_ADDR_W-1:0] dst;
        logic                    wb_en;
    } stage_entry_t;

    localparam stage_entry_t c_BUBBLE = '{dst: '0, wb_en: 1'b0};

endpackage : wb_dst_tracker_pkg
`default_nettype wire

// File: rtl/dst_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : dst_stage_reg
// Description : One pipeline destination entry with load/hold enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dst_stage_reg
    import wb_dst_tracker_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  stage_entry_t i_d,
    output stage_entry_t o_q
);

    stage_entry_t r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= c_BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : dst_stage_reg
`default_nettype wire

// File: rtl/wb_dst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : wb_dst_tracker
// Description : Tracks destination register / write-back enable through
//               EXE, MEM and WB with stall, flush and freeze handling.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dst_tracker
    import wb_dst_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = c_REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wb_en,
    input  logic                  hazard,
    input  logic                  flush,
    input  logic                  freeze,
    output logic [REG_ADDR_W-1:0] exe_dst,
    output logic                  exe_wb_en,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  mem_wb_en,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  wb_wb_en,
    output logic [NUM_REGS-1:0]   busy,
    output logic [1:0]            pending_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int c_NUM_STAGES = 3;

    logic         w_advance;
    logic         w_accept;
    logic         w_count_bubble;
    stage_entry_t w_exe_next;
    stage_entry_t w_stage_d [c_NUM_STAGES];
    stage_entry_t w_stage_q [c_NUM_STAGES];
    logic [NUM_REGS-1:0] w_busy;
    logic [CNT_W-1:0]    r_bubble_cnt;

    // freeze holds everything; otherwise flush/hazard turn the ID slot into a bubble
    assign w_advance      = ~freeze;
    assign w_accept       = id_valid & ~flush & ~hazard;
    assign w_count_bubble = w_advance & id_valid & (flush | hazard);

    always_comb begin
        w_exe_next = c_BUBBLE;
        if (w_accept) begin
            w_exe_next.dst   = id_dst;
            w_exe_next.wb_en = id_wb_en;
        end
    end

    // Stage 0 = EXE, 1 = MEM, 2 = WB; each stage loads from the one before it.
    generate
        for (genvar s = 0; s < c_NUM_STAGES; s++) begin : g_stage
            if (s == 0) begin : g_head
                assign w_stage_d[s] = w_exe_next;
            end else begin : g_chain
                assign w_stage_d[s] = w_stage_q[s-1];
            end

            dst_stage_reg u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_advance),
                .i_d    (w_stage_d[s]),
                .o_q    (w_stage_q[s])
            );
        end
    endgenerate

    always_comb begin
        w_busy = '0;
        for (int s = 0; s < c_NUM_STAGES; s++) begin
            if (w_stage_q[s].wb_en) begin
                w_busy[w_stage_q[s].dst] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (w_count_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign exe_dst     = w_stage_q[0].dst;
    assign exe_wb_en   = w_stage_q[0].wb_en;
    assign mem_dst     = w_stage_q[1].dst;
    assign mem_wb_en   = w_stage_q[1].wb_en;
    assign wb_dst      = w_stage_q[2].dst;
    assign wb_wb_en    = w_stage_q[2].wb_en;
    assign busy        = w_busy;
    assign pending_cnt = {1'b0, w_stage_q[0].wb_en} + {1'b0, w_stage_q[1].wb_en}
                       + {1'b0, w_stage_q[2].wb_en};
    assign bubble_cnt  = r_bubble_cnt;

endmodule : wb_dst_tracker
`default_nettype wire

// File: tb/tb_wb_dst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dst_tracker
// Description : Directed vector bench for wb_dst_tracker (bubble counter 4 bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dst_tracker;

    localparam int c_CNT_W = 4;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_dst;
    logic        id_wb_en;
    logic        hazard;
    logic        flush;
    logic        freeze;
    logic [3:0]  exe_dst;
    logic        exe_wb_en;
    logic [3:0]  mem_dst;
    logic        mem_wb_en;
    logic [3:0]  wb_dst;
    logic        wb_wb_en;
    logic [15:0] busy;
    logic [1:0]  pending_cnt;
    logic [c_CNT_W-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    wb_dst_tracker #(
        .REG_ADDR_W (4),
        .NUM_REGS   (16),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_dst      (id_dst),
        .id_wb_en    (id_wb_en),
        .hazard      (hazard),
        .flush       (flush),
        .freeze      (freeze),
        .exe_dst     (exe_dst),
        .exe_wb_en   (exe_wb_en),
        .mem_dst     (mem_dst),
        .mem_wb_en   (mem_wb_en),
        .wb_dst      (wb_dst),
        .wb_wb_en    (wb_wb_en),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [3:0]  dst;
        logic        en;
        logic        haz;
        logic        fl;
        logic        fz;
        logic [3:0]  e_d;
        logic        e_en;
        logic [3:0]  m_d;
        logic        m_en;
        logic [3:0]  w_d;
        logic        w_en;
        logic [15:0] busy;
        logic [1:0]  pend;
        logic [3:0]  bub;
    } vec_t;

    localparam int c_NVEC = 20;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(
        input logic v, input logic [3:0] dst, input logic en,
        input logic haz, input logic fl, input logic fz,
        input logic [3:0] e_d, input logic e_en,
        input logic [3:0] m_d, input logic m_en,
        input logic [3:0] w_d, input logic w_en,
        input logic [15:0] b, input logic [1:0] p, input logic [3:0] bub);
        vec_t r;
        r.v = v; r.dst = dst; r.en = en; r.haz = haz; r.fl = fl; r.fz = fz;
        r.e_d = e_d; r.e_en = e_en; r.m_d = m_d; r.m_en = m_en;
        r.w_d = w_d; r.w_en = w_en; r.busy = b; r.pend = p; r.bub = bub;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, ".exe_dst"},     32'(exe_dst),     32'(e.e_d));
        chk({tag, ".exe_wb_en"},   32'(exe_wb_en),   32'(e.e_en));
        chk({tag, ".mem_dst"},     32'(mem_dst),     32'(e.m_d));
        chk({tag, ".mem_wb_en"},   32'(mem_wb_en),   32'(e.m_en));
        chk({tag, ".wb_dst"},      32'(wb_dst),      32'(e.w_d));
        chk({tag, ".wb_wb_en"},    32'(wb_wb_en),    32'(e.w_en));
        chk({tag, ".busy"},        32'(busy),        32'(e.busy));
        chk({tag, ".pending_cnt"}, 32'(pending_cnt), 32'(e.pend));
        chk({tag, ".bubble_cnt"},  32'(bubble_cnt),  32'(e.bub));
    endtask

    task automatic drive(input vec_t e);
        id_valid = e.v; id_dst = e.dst; id_wb_en = e.en;
        hazard = e.haz; flush = e.fl; freeze = e.fz;
    endtask

    vec_t zero_st;
    vec_t tmp;

    initial begin
        //            v  dst en hz fl fz  exe      mem      wb       busy     p  bub
        vecs[0]  = mk(1, 3, 1, 0, 0, 0,  3, 1,    0, 0,    0, 0,  16'h0008, 1, 0);
        vecs[1]  = mk(1, 5, 1, 0, 0, 0,  5, 1,    3, 1,    0, 0,  16'h0028, 2, 0);
        vecs[2]  = mk(1, 7, 0, 0, 0, 0,  7, 0,    5, 1,    3, 1,  16'h0028, 2, 0);
        vecs[3]  = mk(1, 4, 1, 1, 0, 0,  0, 0,    7, 0,    5, 1,  16'h0020, 1, 1);
        vecs[4]  = mk(1, 4, 1, 1, 0, 0,  0, 0,    0, 0,    7, 0,  16'h0000, 0, 2);
        vecs[5]  = mk(1, 4, 1, 0, 0, 0,  4, 1,    0, 0,    0, 0,  16'h0010, 1, 2);
        vecs[6]  = mk(0, 2, 1, 0, 0, 0,  0, 0,    4, 1,    0, 0,  16'h0010, 1, 2);
        vecs[7]  = mk(0, 2, 1, 1, 0, 0,  0, 0,    0, 0,    4, 1,  16'h0010, 1, 2);
        vecs[8]  = mk(1, 9, 1, 1, 1, 0,  0, 0,    0, 0,    0, 0,  16'h0000, 0, 3);
        vecs[9]  = mk(1, 9, 1, 0, 1, 0,  0, 0,    0, 0,    0, 0,  16'h0000, 0, 4);
        vecs[10] = mk(1, 3, 1, 0, 0, 0,  3, 1,    0, 0,    0, 0,  16'h0008, 1, 4);
        vecs[11] = mk(1, 2, 1, 0, 0, 0,  2, 1,    3, 1,    0, 0,  16'h000C, 2, 4);
        vecs[12] = mk(1, 1, 1, 0, 0, 0,  1, 1,    2, 1,    3, 1,  16'h000E, 3, 4);
        vecs[13] = mk(1, 6, 1, 1, 0, 1,  1, 1,    2, 1,    3, 1,  16'h000E, 3, 4);
        vecs[14] = mk(1, 6, 1, 1, 0, 1,  1, 1,    2, 1,    3, 1,  16'h000E, 3, 4);
        vecs[15] = mk(1, 6, 1, 1, 1, 1,  1, 1,    2, 1,    3, 1,  16'h000E, 3, 4);
        vecs[16] = mk(1, 6, 1, 0, 0, 0,  6, 1,    1, 1,    2, 1,  16'h0046, 3, 4);
        vecs[17] = mk(1, 6, 1, 0, 0, 0,  6, 1,    6, 1,    1, 1,  16'h0042, 3, 4);
        vecs[18] = mk(1, 6, 0, 0, 0, 0,  6, 0,    6, 1,    6, 1,  16'h0040, 2, 4);
        vecs[19] = mk(1, 8, 1, 1, 0, 1,  6, 0,    6, 1,    6, 1,  16'h0040, 2, 4);

        zero_st = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  16'h0000, 0, 0);

        rst = 1'b0;
        drive(zero_st);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero_st);
        rst = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges with a populated pipeline.
        drive(zero_st);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", zero_st);
        #2;
        rst = 1'b1;
        tmp = mk(1, 8, 1, 0, 0, 0,  8, 1, 0, 0, 0, 0,  16'h0100, 1, 0);
        drive(tmp);
        @(posedge clk);
        #1;
        check_all("after_rst", tmp);

        // Long stall run drives the 4-bit counter into saturation.
        for (int i = 1; i <= 20; i++) begin
            tmp = mk(1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0,  16'h0000, 0, 0);
            drive(tmp);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.bubble_cnt", i), 32'(bubble_cnt),
                32'((i < 15) ? i : 15));
            chk($sformatf("sat%0d.exe_wb_en", i), 32'(exe_wb_en), 32'd0);
        end
        chk("sat_final.busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_dst_tracker
`default_nettype wire

// File: doc/wb_dst_tracker.md
Name: wb_dst_tracker

Overview:
- Producer side of the pipeline's destination-register bookkeeping. Tracks every issued instruction's destination register and write-back enable through the EXE, MEM and WB stages.
- Drives the exe_dst/exe_wb_en and mem_dst/mem_wb_en signals that the hazard detector compares against source registers.
- Takes the hazard (stall), branch-flush and memory-freeze controls as inputs and inserts bubbles accordingly.
- Also provides a per-register busy mask and a bubble statistics counter.

Parameters:
- REG_ADDR_W, 4, width of a register index.
- NUM_REGS, 16, number of architectural registers (2**REG_ADDR_W).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock domain, asynchronous, active-low (rst=0 resets).
- id_valid  input  1  ID stage holds a real instruction.
- id_dst  input  REG_ADDR_W  destination register of the ID instruction.
- id_wb_en  input  1  ID instruction writes the register file.
- hazard  input  1  stall request from the hazard detector.
- flush  input  1  branch taken in EXE; kill the ID instruction.
- freeze  input  1  memory stall; hold every stage.
- exe_dst  output  REG_ADDR_W  destination in EXE.
- exe_wb_en  output  1  EXE entry will write back.
- mem_dst  output  REG_ADDR_W  destination in MEM.
- mem_wb_en  output  1  MEM entry will write back.
- wb_dst  output  REG_ADDR_W  destination in WB.
- wb_wb_en  output  1  WB entry writes this cycle.
- busy  output  NUM_REGS  bit r=1 when any of EXE/MEM/WB holds a write to r.
- pending_cnt  output  2  number of stages (EXE/MEM/WB) with wb_en=1, saturates naturally at 3.
- bubble_cnt  output  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all *_wb_en=0, all *_dst=0, busy=0, pending_cnt=0, bubble_cnt=0. Reset asserted mid-stream discards all in-flight entries immediately, without waiting for a clock edge.
- Stage entry = {dst, wb_en}. A bubble is {0, 0}.
- Priority per rising edge: freeze > flush > hazard > normal.
- freeze=1: all three stages and bubble_cnt hold. hazard and flush are ignored that cycle.
- Otherwise:
  - wb <= mem, mem <= exe.
  - exe <= {id_dst, id_wb_en} when id_valid=1 and flush=0 and hazard=0; else exe <= bubble.
- Bubble counting: bubble_cnt increments by 1 on every non-frozen edge where exe loads a bubble because of flush or hazard while id_valid=1. id_valid=0 loads a bubble but does not count. The counter saturates at all-ones and does not wrap.
- Latency: an ID entry accepted at edge N is visible on exe_* after N, on mem_* after N+1, and on wb_* after N+2.
- busy and pending_cnt are combinational from the stage registers (no extra latency).
  - busy is the OR over stages of a one-hot decode of dst, gated by that stage's wb_en.
  - The same dst in several stages still sets a single bit.
- An entry with wb_en=0 is carried through the stages but never sets busy, and its dst is still propagated.
- When hazard is held for k cycles, k bubbles enter EXE and the ID instruction is accepted on the first edge with hazard=0.
- flush and hazard asserted together: one bubble, counted once.

Decomposition:
- Shared package:
  - REG_ADDR_W and NUM_REGS constants.
  - A stage-entry struct {dst, wb_en} and a BUBBLE constant, also usable by the hazard detector and forwarding logic.
- Sub-module dst_stage_reg: one entry register with asynchronous active-low reset and load/hold enable. Instantiated three times.
- Top level holds the next-entry mux, busy decode, pending count and bubble counter.

Test Plan:
- Reset then stream: id_valid=1, (dst,wb_en) = (3,1), (5,1), (7,0) on consecutive edges → after the 3rd edge: exe=(7,0), mem=(5,1), wb=(3,1); busy=0x0028; pending_cnt=2.
- Hazard: hazard=1 for 2 cycles with ID=(4,1) → two bubbles in EXE, bubble_cnt=2; ID entry appears on exe_* at the 3rd edge; busy bit 4 is set only from then on.
- Freeze: with pipeline (exe=(1,1), mem=(2,1), wb=(3,1)), freeze=1 and hazard=1 for 3 cycles → all outputs unchanged and bubble_cnt unchanged; release freeze → normal shift resumes.
- Flush plus hazard together with ID=(9,1) → exe=bubble; bubble_cnt increments by exactly 1; bit 9 of busy stays 0.
- Asynchronous reset: pull rst low between clock edges with all stages valid → outputs go to 0 before the next edge; pipeline restarts cleanly after rst returns to 1.
- Saturation: preload via a long hazard run with CNT_W=4 for 20 cycles → bubble_cnt=15 and stays there.
